// File: rtl/qk_core_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// qk_ctrl_pkg
// Shared definitions for the QK attention core sequencer: the phase enum,
// the bit positions of the fixed 19-bit core instruction word and the SFP
// timing constants.
// ----------------------------------------------------------------------------
package qk_ctrl_pkg;

    // Sequencer phases, in the order a normal run walks through them
    typedef enum logic [3:0] {
        IDLE,
        WR_Q,
        WR_K,
        LOAD,
        GAP1,
        EXEC,
        GAP2,
        MOVE,
        SFP,
        TAIL,
        DONE
    } qk_state_t;

    // Instruction word layout
    localparam int BIT_DIV      = 18;
    localparam int BIT_ACC      = 17;
    localparam int BIT_OFIFO_RD = 16;
    localparam int QK_ADD_LSB   = 12;
    localparam int P_ADD_LSB    = 8;
    localparam int BIT_EXEC     = 7;
    localparam int BIT_LOAD     = 6;
    localparam int BIT_Q_RD     = 5;
    localparam int BIT_Q_WR     = 4;
    localparam int BIT_K_RD     = 3;
    localparam int BIT_K_WR     = 2;
    localparam int BIT_P_RD     = 1;
    localparam int BIT_P_WR     = 0;
    localparam int ADDR_FIELD_W = 4;

    // SFP timing: six cycles per row (idle, acc, acc, idle, div, div), then
    // two trailing div cycles after the last row
    localparam int SFP_ROW_CYC  = 6;
    localparam int SFP_TAIL_CYC = 2;

endpackage

// File: rtl/qk_core_sequencer_sfp_phase_seq.sv
// ----------------------------------------------------------------------------
// sfp_phase_seq
// Phase counter for one SFP row. While enabled it steps through the six
// phases of a row and decodes the acc/div strobes for the current phase.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous, active-low reset
//   en       in   high while the sequencer is in its SFP phase
//   acc      out  accumulate strobe for the current phase
//   div      out  divide strobe for the current phase
//   row_done out  high in the last phase of a row
// ----------------------------------------------------------------------------
module sfp_phase_seq
    import qk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic acc,
    output logic div,
    output logic row_done
);

    localparam logic [2:0] PHASE_LAST = 3'(SFP_ROW_CYC - 1);

    logic [2:0] phase;

    // Phase restarts whenever the sequencer leaves SFP so an aborted run
    // never leaves a half-finished row behind
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (!en || phase == PHASE_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 3'd1;
        end
    end

    assign acc      = en && (phase == 3'd1 || phase == 3'd2);
    assign div      = en && (phase >= 3'd4);
    assign row_done = en && (phase == PHASE_LAST);

endmodule

// File: rtl/qk_core_sequencer.sv
// ----------------------------------------------------------------------------
// qk_core_sequencer
// Autonomous controller for one QK attention core. A start pulse writes n_q
// Q rows and COL K rows from the host beat stream, loads K into the PE array,
// executes, drains ofifo into pmem and runs the SFP acc/div sequence per row.
//
// Every output is a register. The instruction word is issued the cycle after
// the condition it answers was sampled: a host beat accepted on a clock edge
// (in_valid && in_ready) shows up as q_wr/k_wr in the following cycle, and a
// non-empty ofifo sampled on an edge shows up as ofifo_rd/p_wr in the
// following cycle. The core's mem_in path must therefore carry the beat
// forward by one register stage.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-low reset
//   start      in   run request, accepted only when idle and n_q != 0
//   abort      in   return to IDLE on the next edge from any phase
//   n_q        in   number of Q rows (1..2**ADDR_W), latched on start
//   in_valid   in   host Q/K beat valid
//   in_ready   out  a beat is consumed this cycle (WR_Q/WR_K)
//   fifo_empty in   core ofifo empty
//   inst       out  core instruction word
//   busy       out  run in progress (stays high through the done cycle)
//   done       out  one-cycle pulse after the SFP tail
// ----------------------------------------------------------------------------
module qk_core_sequencer
    import qk_ctrl_pkg::*;
#(
    parameter int COL    = 8,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 10,
    parameter int INST_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   n_q,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fifo_empty,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (COL + 2 > SETTLE) ? COL + 2 : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LOAD_LAST   = CNT_W'(COL + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  TAIL_LAST   = CNT_W'(SFP_TAIL_CYC - 1);
    localparam logic [ADDR_W:0]   ROW_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   K_LAST      = (ADDR_W + 1)'(COL - 1);

    qk_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [ADDR_W:0]  row;
    logic [ADDR_W:0]  nq_last;
    logic             sfp_acc;
    logic             sfp_div;
    logic             sfp_row_done;

    sfp_phase_seq u_sfp_phase_seq (
        .clk      (clk),
        .reset    (reset),
        .en       (state == SFP),
        .acc      (sfp_acc),
        .div      (sfp_div),
        .row_done (sfp_row_done)
    );

    // Main sequencer. Each branch decides the next phase and the instruction
    // word for the next cycle; inst and done fall back to zero unless a branch
    // drives them. Abort overrides whatever the current phase would do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            row      <= '0;
            nq_last  <= '0;
            inst     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            inst <= '0;
            done <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                cnt      <= '0;
                row      <= '0;
                in_ready <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // busy still high here means the done pulse is on
                        // the outputs; a new run waits one more cycle
                        if (start && n_q != '0 && !busy) begin
                            nq_last  <= n_q - ROW_ONE;
                            row      <= '0;
                            cnt      <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= WR_Q;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    WR_Q: begin
                        if (in_valid) begin
                            inst[BIT_Q_WR] <= 1'b1;
                            inst[QK_ADD_LSB +: ADDR_FIELD_W] <= ADDR_FIELD_W'(row);
                            if (row == nq_last) begin
                                row   <= '0;
                                state <= WR_K;
                            end else begin
                                row <= row + ROW_ONE;
                            end
                        end
                    end
                    WR_K: begin
                        if (in_valid) begin
                            inst[BIT_K_WR] <= 1'b1;
                            inst[QK_ADD_LSB +: ADDR_FIELD_W] <= ADDR_FIELD_W'(row);
                            if (row == K_LAST) begin
                                row      <= '0;
                                cnt      <= '0;
                                in_ready <= 1'b0;
                                state    <= LOAD;
                            end else begin
                                row <= row + ROW_ONE;
                            end
                        end
                    end
                    LOAD: begin
                        // First and last LOAD cycles assert load alone; the
                        // COL cycles between also read K row cnt-1
                        inst[BIT_LOAD] <= 1'b1;
                        if (cnt != '0 && cnt != LOAD_LAST) begin
                            inst[BIT_K_RD] <= 1'b1;
                            inst[QK_ADD_LSB +: ADDR_FIELD_W] <= ADDR_FIELD_W'(cnt - CNT_ONE);
                        end
                        if (cnt == LOAD_LAST) begin
                            cnt   <= '0;
                            state <= GAP1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    GAP1, GAP2: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            row   <= '0;
                            state <= (state == GAP1) ? EXEC : MOVE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    EXEC: begin
                        inst[BIT_EXEC] <= 1'b1;
                        inst[BIT_Q_RD] <= 1'b1;
                        inst[QK_ADD_LSB +: ADDR_FIELD_W] <= ADDR_FIELD_W'(row);
                        if (row == nq_last) begin
                            row   <= '0;
                            cnt   <= '0;
                            state <= GAP2;
                        end else begin
                            row <= row + ROW_ONE;
                        end
                    end
                    MOVE: begin
                        if (!fifo_empty) begin
                            inst[BIT_OFIFO_RD] <= 1'b1;
                            inst[BIT_P_WR]     <= 1'b1;
                            inst[P_ADD_LSB +: ADDR_FIELD_W] <= ADDR_FIELD_W'(row);
                            if (row == nq_last) begin
                                row   <= '0;
                                state <= SFP;
                            end else begin
                                row <= row + ROW_ONE;
                            end
                        end
                    end
                    SFP: begin
                        inst[BIT_P_RD] <= 1'b1;
                        inst[BIT_ACC]  <= sfp_acc;
                        inst[BIT_DIV]  <= sfp_div;
                        inst[P_ADD_LSB +: ADDR_FIELD_W] <= ADDR_FIELD_W'(row);
                        if (sfp_row_done) begin
                            if (row == nq_last) begin
                                row   <= '0;
                                cnt   <= '0;
                                state <= TAIL;
                            end else begin
                                row <= row + ROW_ONE;
                            end
                        end
                    end
                    TAIL: begin
                        inst[BIT_DIV] <= 1'b1;
                        if (cnt == TAIL_LAST) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qk_core_sequencer.sv
// ----------------------------------------------------------------------------
// tb_qk_core_sequencer
// Scoreboard bench for qk_core_sequencer. Starting a run pushes the full list
// of non-zero instruction words (plus the done pulse) a run must produce, in
// order; a monitor pops one entry for every cycle where the DUT shows a
// non-zero word or done, and also checks beat/write and fifo/read pairing.
// ----------------------------------------------------------------------------
module tb_qk_core_sequencer;

    localparam int COL     = 8;
    localparam int ADDR_W  = 4;
    localparam int SETTLE  = 10;
    localparam int INST_W  = 19;
    localparam int ROW_CYC = 6;

    localparam int M_DIV   = 1 << 18;
    localparam int M_ACC   = 1 << 17;
    localparam int M_OFIFO = 1 << 16;
    localparam int M_EXEC  = 1 << 7;
    localparam int M_LOAD  = 1 << 6;
    localparam int M_Q_RD  = 1 << 5;
    localparam int M_Q_WR  = 1 << 4;
    localparam int M_K_RD  = 1 << 3;
    localparam int M_K_WR  = 1 << 2;
    localparam int M_P_RD  = 1 << 1;
    localparam int M_P_WR  = 1 << 0;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   n_q;
    logic              in_valid;
    logic              in_ready;
    logic              fifo_empty;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          valid_mode = 0;
    int          empty_mode = 0;
    logic [19:0] sb[$];

    qk_core_sequencer #(
        .COL    (COL),
        .ADDR_W (ADDR_W),
        .SETTLE (SETTLE),
        .INST_W (INST_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .n_q        (n_q),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_empty (fifo_empty),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [18:0] mk(int bits, int qk, int p);
        logic [18:0] w;
        w        = 19'(bits);
        w[15:12] = 4'(qk);
        w[11:8]  = 4'(p);
        return w;
    endfunction

    // Cycles from the cycle start is driven to the cycle done is visible:
    // one to accept start, then every phase length in order, plus stalls
    function automatic int model_latency(int nq, int stall);
        return 1 + nq + COL + (COL + 2) + SETTLE + nq + SETTLE + nq
               + ROW_CYC * nq + 2 + 1 + stall;
    endfunction

    function automatic int run_length(int nq);
        return nq + COL + (COL + 2) + nq + nq + ROW_CYC * nq + 2 + 1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got,
                                input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_run(input int nq);
        int m;
        for (int r = 0; r < nq; r++) sb.push_back({1'b0, mk(M_Q_WR, r, 0)});
        for (int r = 0; r < COL; r++) sb.push_back({1'b0, mk(M_K_WR, r, 0)});
        sb.push_back({1'b0, mk(M_LOAD, 0, 0)});
        for (int c = 0; c < COL; c++) sb.push_back({1'b0, mk(M_LOAD | M_K_RD, c, 0)});
        sb.push_back({1'b0, mk(M_LOAD, 0, 0)});
        for (int r = 0; r < nq; r++) sb.push_back({1'b0, mk(M_EXEC | M_Q_RD, r, 0)});
        for (int r = 0; r < nq; r++) sb.push_back({1'b0, mk(M_OFIFO | M_P_WR, 0, r)});
        for (int r = 0; r < nq; r++) begin
            for (int ph = 0; ph < ROW_CYC; ph++) begin
                m = M_P_RD;
                if (ph == 1 || ph == 2) m = m | M_ACC;
                if (ph >= 4) m = m | M_DIV;
                sb.push_back({1'b0, mk(m, 0, r)});
            end
        end
        sb.push_back({1'b0, mk(M_DIV, 0, 0)});
        sb.push_back({1'b0, mk(M_DIV, 0, 0)});
        sb.push_back({1'b1, 19'b0});
    endtask

    // Queue the expected run, pulse start for one cycle, report the cycle
    // number in which start was driven
    task automatic apply_stimulus(input int nq, output int k);
        push_run(nq);
        n_q   = 5'(nq);
        start = 1'b1;
        k     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("drain", 32'(sb.size()), 0);
        sb.delete();
        @(posedge clk);
        #1;
        check_output("idle_busy", 32'(busy), 0);
    endtask

    task automatic wait_popped(input int remaining);
        int n;
        n = 0;
        while (sb.size() > remaining && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("reach_point", 32'(sb.size() <= remaining), 1);
    endtask

    // Input driver: in_valid always high, random or toggling; fifo_empty
    // never, random, or left to the test sequence (mode 2)
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (valid_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ($urandom_range(0, 3) != 0);
                default: in_valid = ~in_valid;
            endcase
            if (empty_mode == 0) fifo_empty = 1'b0;
            else if (empty_mode == 1) fifo_empty = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: every visible word or done pulse consumes one scoreboard entry
    initial begin
        logic [19:0] exp_word;
        logic        wr;
        logic        prev_beat;
        logic        prev_empty;
        prev_beat  = 1'b0;
        prev_empty = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                wr = inst[4] | inst[2];
                if (inst != '0 || done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_event: got %0h expected none",
                                 {done, inst});
                    end else begin
                        exp_word = sb.pop_front();
                        check_output("event", 32'({done, inst}), 32'(exp_word));
                    end
                    if (done) begin
                        done_cyc = cyc;
                        done_cnt++;
                    end
                    check_output("mem_onehot",
                                 32'($onehot0({inst[5], inst[4], inst[3], inst[2], inst[1], inst[0]})), 1);
                    check_output("acc_div_excl", 32'(inst[17] & inst[18]), 0);
                    if (inst[16]) check_output("ofifo_after_nonempty", 32'(prev_empty), 0);
                end
                if (wr || prev_beat) check_output("beat_write", 32'(wr), 32'(prev_beat));
            end
            prev_beat  = reset && in_valid && in_ready && !abort;
            prev_empty = fifo_empty;
        end
    end

    initial begin
        int k;
        int nq;
        int base;
        int saved;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        n_q        = '0;
        in_valid   = 1'b0;
        fifo_empty = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_inst", 32'(inst), 0);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_ready", 32'(in_ready), 0);
        check_output("reset_done", 32'(done), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full run, back-to-back beats, no ofifo stalls
        $display("[TB] n_q=8 continuous");
        apply_stimulus(8, k);
        wait_drain(2000);
        check_output("latency_n8", 32'(done_cyc - k), 32'(model_latency(8, 0)));

        // Reset pulled in the middle of EXEC, then a clean run
        $display("[TB] reset mid-EXEC");
        apply_stimulus(8, k);
        base = run_length(8);
        wait_popped(base - (8 + COL + COL + 2 + 3));
        reset = 1'b0;
        #1;
        check_output("midreset_inst", 32'(inst), 0);
        check_output("midreset_busy", 32'(busy), 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(8, k);
        wait_drain(2000);
        check_output("latency_after_reset", 32'(done_cyc - k), 32'(model_latency(8, 0)));

        // Beats on alternate cycles
        $display("[TB] toggling in_valid");
        valid_mode = 2;
        apply_stimulus(8, k);
        wait_drain(2000);
        valid_mode = 0;

        // ofifo empty for three cycles in the middle of MOVE
        $display("[TB] ofifo stall");
        empty_mode = 2;
        fifo_empty = 1'b0;
        apply_stimulus(8, k);
        base = run_length(8);
        wait_popped(base - (8 + COL + COL + 2 + 8 + 3));
        fifo_empty = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        fifo_empty = 1'b0;
        wait_drain(2000);
        check_output("latency_stall", 32'(done_cyc - k), 32'(model_latency(8, 3)));
        empty_mode = 0;

        // Largest row count, then a start with n_q=0
        $display("[TB] n_q=16 and n_q=0");
        apply_stimulus(16, k);
        wait_drain(3000);
        check_output("latency_n16", 32'(done_cyc - k), 32'(model_latency(16, 0)));
        n_q   = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("nq0_busy", 32'(busy), 0);
        check_output("nq0_ready", 32'(in_ready), 0);

        // Start while busy is ignored; abort in SFP row 3 suppresses done
        $display("[TB] start while busy, abort in SFP");
        apply_stimulus(8, k);
        n_q   = 5'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = run_length(8);
        wait_popped(base - (8 + COL + COL + 2 + 8 + 8 + 3 * ROW_CYC + 3));
        saved = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        sb.delete();
        check_output("abort_busy", 32'(busy), 0);
        check_output("abort_ready", 32'(in_ready), 0);
        repeat (20) @(posedge clk);
        #1;
        check_output("abort_no_done", 32'(done_cnt), 32'(saved));

        // Random row counts with random beats and random ofifo stalls
        $display("[TB] random runs");
        valid_mode = 1;
        empty_mode = 1;
        for (int i = 0; i < 4; i++) begin
            nq = int'($urandom_range(1, 16));
            apply_stimulus(nq, k);
            wait_drain(4000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
